// File: rtl/dino_pkg.sv
// Shared definitions for the dino runner: state encoding for vertical motion and the
// default physics constants used by the jump engine, player FSM and collision block.
package dino_pkg;

  localparam int unsigned DINO_POS_W        = 8;
  localparam int unsigned DINO_VEL_W        = 5;
  localparam int unsigned DINO_JUMP_VEL     = 8;
  localparam int unsigned DINO_GRAVITY      = 1;
  localparam int unsigned DINO_FAST_GRAVITY = 2;
  localparam int unsigned DINO_MAX_FALL     = 8;

  typedef enum logic [1:0] {
    GROUNDED = 2'd0,
    RISING   = 2'd1,
    FALLING  = 2'd2
  } phys_state_t;

endpackage

// File: rtl/jump_physics_engine.sv
// Vertical-motion integrator: takes jump requests and fast-fall level, updates height
// once per physics tick, and raises a sticky landing flag for the player FSM.
module jump_physics_engine
  import dino_pkg::*;
#(
  parameter int unsigned POS_W        = DINO_POS_W,
  parameter int unsigned VEL_W        = DINO_VEL_W,
  parameter int unsigned JUMP_VEL     = DINO_JUMP_VEL,
  parameter int unsigned GRAVITY      = DINO_GRAVITY,
  parameter int unsigned FAST_GRAVITY = DINO_FAST_GRAVITY,
  parameter int unsigned MAX_FALL     = DINO_MAX_FALL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       game_tick,
  input  logic             jump_pulse,
  input  logic             button_down,
  output logic [POS_W-1:0] position,
  output logic             jump_done,
  output logic             airborne
);

  phys_state_t      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [VEL_W-1:0] rise_vel_q, rise_vel_d;
  logic [VEL_W-1:0] fall_vel_q, fall_vel_d;
  logic             jd_q, jd_d;
  logic             air_q, air_d;
  logic [VEL_W-1:0] g_s;
  logic [VEL_W:0]   nv_sum_s;
  logic [VEL_W:0]   nv_s;

  // Height plus velocity with a one-bit-wider intermediate, clamped at full scale.
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0] a,
                                                input logic [VEL_W:0]   b);
    logic [POS_W:0] s;
    s = {1'b0, a} + (POS_W+1)'(b);
    if (s[POS_W]) begin
      return {POS_W{1'b1}};
    end else begin
      return s[POS_W-1:0];
    end
  endfunction

  // Height minus velocity, floored at ground.
  function automatic logic [POS_W-1:0] sat_sub(input logic [POS_W-1:0] a,
                                                input logic [VEL_W:0]   b);
    logic [POS_W:0] s;
    if ((POS_W+1)'(b) >= {1'b0, a}) begin
      return {POS_W{1'b0}};
    end else begin
      s = {1'b0, a} - (POS_W+1)'(b);
      return s[POS_W-1:0];
    end
  endfunction

  // Next-state, height, velocity and landing-flag logic.
  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    rise_vel_d = rise_vel_q;
    fall_vel_d = fall_vel_q;
    jd_d       = jd_q;
    g_s        = button_down ? VEL_W'(FAST_GRAVITY) : VEL_W'(GRAVITY);
    nv_sum_s   = {1'b0, fall_vel_q} + {1'b0, g_s};
    if (nv_sum_s > (VEL_W+1)'(MAX_FALL)) begin
      nv_s = (VEL_W+1)'(MAX_FALL);
    end else begin
      nv_s = nv_sum_s;
    end
    // Frame tick clears first so a landing in the same cycle overrides it.
    if (game_tick[1]) begin
      jd_d = 1'b0;
    end else begin
      jd_d = jd_q;
    end
    case (state_q)
      GROUNDED: begin
        if (jump_pulse) begin
          rise_vel_d = VEL_W'(JUMP_VEL);
          jd_d       = 1'b0;
          state_d    = RISING;
        end else begin
          state_d = GROUNDED;
        end
      end
      RISING: begin
        if (game_tick[0]) begin
          pos_d = sat_add(pos_q, {1'b0, rise_vel_q});
          if (rise_vel_q <= g_s) begin
            state_d    = FALLING;
            fall_vel_d = {VEL_W{1'b0}};
          end else begin
            rise_vel_d = rise_vel_q - g_s;
          end
        end else begin
          state_d = RISING;
        end
      end
      FALLING: begin
        if (game_tick[0]) begin
          if ({1'b0, pos_q} <= (POS_W+1)'(nv_s)) begin
            pos_d   = {POS_W{1'b0}};
            state_d = GROUNDED;
            jd_d    = 1'b1;
          end else begin
            pos_d      = sat_sub(pos_q, nv_s);
            fall_vel_d = nv_s[VEL_W-1:0];
          end
        end else begin
          state_d = FALLING;
        end
      end
      default: begin
        state_d = GROUNDED;
      end
    endcase
    air_d = (state_d != GROUNDED);
  end

  // State and output registers, cleared immediately by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= GROUNDED;
      pos_q      <= {POS_W{1'b0}};
      rise_vel_q <= {VEL_W{1'b0}};
      fall_vel_q <= {VEL_W{1'b0}};
      jd_q       <= 1'b0;
      air_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      rise_vel_q <= rise_vel_d;
      fall_vel_q <= fall_vel_d;
      jd_q       <= jd_d;
      air_q      <= air_d;
    end
  end

  assign position  = pos_q;
  assign jump_done = jd_q;
  assign airborne  = air_q;

endmodule

// File: tb/tb_jump_physics_engine.sv
// Bench for jump_physics_engine: a default instance and a JUMP_VEL=31 instance share
// stimulus and are compared each cycle against a signed-velocity reference model.
module tb_jump_physics_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] game_tick;
  logic       jump_pulse;
  logic       button_down;
  logic [7:0] position_a, position_b;
  logic       jump_done_a, jump_done_b;
  logic       airborne_a, airborne_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: height, signed velocity (positive = up), in-air flag, landing flag.
  int mh[2];
  int mv[2];
  bit mair[2];
  bit mjd[2];
  int mjv[2] = '{8, 31};

  int exp1[16] = '{8, 15, 21, 26, 30, 33, 35, 36, 35, 33, 30, 26, 21, 15, 8, 0};
  int exp2[8]  = '{8, 14, 18, 20, 18, 14, 8, 0};

  always #5 clk = ~clk;

  jump_physics_engine u_dut_a (
    .clk(clk), .reset(reset), .game_tick(game_tick), .jump_pulse(jump_pulse),
    .button_down(button_down), .position(position_a), .jump_done(jump_done_a),
    .airborne(airborne_a)
  );

  jump_physics_engine #(.JUMP_VEL(31)) u_dut_b (
    .clk(clk), .reset(reset), .game_tick(game_tick), .jump_pulse(jump_pulse),
    .button_down(button_down), .position(position_b), .jump_done(jump_done_b),
    .airborne(airborne_b)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mh[m] = 0; mv[m] = 0; mair[m] = 1'b0; mjd[m] = 1'b0;
    end
  endtask

  task automatic model_step(input int m, input bit t0, input bit t1, input bit jp, input bit bd);
    int g;
    int nv;
    g = bd ? 2 : 1;
    if (t1) mjd[m] = 1'b0;
    if (!mair[m]) begin
      if (jp) begin
        mv[m] = mjv[m]; mair[m] = 1'b1; mjd[m] = 1'b0;
      end
    end else if (t0) begin
      if (mv[m] > 0) begin
        mh[m] = (mh[m] + mv[m] > 255) ? 255 : mh[m] + mv[m];
        mv[m] = (mv[m] <= g) ? 0 : mv[m] - g;
      end else begin
        nv = -mv[m] + g;
        if (nv > 8) nv = 8;
        if (mh[m] <= nv) begin
          mh[m] = 0; mv[m] = 0; mair[m] = 1'b0; mjd[m] = 1'b1;
        end else begin
          mh[m] = mh[m] - nv; mv[m] = -nv;
        end
      end
    end
  endtask

  task automatic compare_all();
    check_eq("pos_a", int'(position_a), mh[0]);
    check_eq("done_a", int'(jump_done_a), int'(mjd[0]));
    check_eq("air_a", int'(airborne_a), int'(mair[0]));
    check_eq("pos_b", int'(position_b), mh[1]);
    check_eq("done_b", int'(jump_done_b), int'(mjd[1]));
    check_eq("air_b", int'(airborne_b), int'(mair[1]));
  endtask

  task automatic drive_cycle(input bit t0, input bit t1, input bit jp, input bit bd);
    @(negedge clk);
    game_tick   = {t1, t0};
    jump_pulse  = jp;
    button_down = bd;
    @(posedge clk);
    model_step(0, t0, t1, jp, bd);
    model_step(1, t0, t1, jp, bd);
    #1;
    compare_all();
  endtask

  task automatic sync_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    bit jp;
    int maxp;
    bit landed;
    reset = 1'b1; game_tick = 2'b00; jump_pulse = 1'b0; button_down = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    compare_all();

    // Plain jump at normal gravity.
    drive_cycle(1'b1, 1'b0, 1'b1, 1'b0);
    check_eq("t1_pulse_pos", int'(position_a), 0);
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("t1_traj", int'(position_a), exp1[i]);
    end
    check_eq("t1_done", int'(jump_done_a), 1);

    // Fast fall held for the whole jump.
    sync_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b1);
      check_eq("t2_traj", int'(position_a), exp2[i]);
    end
    check_eq("t2_done", int'(jump_done_a), 1);

    // Mid-air pulses are ignored.
    sync_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      jp = (i == 2) || (i == 9);
      drive_cycle(1'b1, 1'b0, jp, 1'b0);
      check_eq("t3_traj", int'(position_a), exp1[i]);
    end

    // Landing coincident with a frame tick, then clear by frame tick and by pulse.
    sync_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 15; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(1'b1, 1'b1, 1'b0, 1'b0);
    check_eq("t4_land_set", int'(jump_done_a), 1);
    drive_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("t4_hold", int'(jump_done_a), 1);
    drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("t4_clear", int'(jump_done_a), 0);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t4_land2", int'(jump_done_a), 1);
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("t4_pulse_clear", int'(jump_done_a), 0);

    // Asynchronous reset mid-jump, then a clean repeat of the plain jump.
    sync_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("t5_pre", int'(position_a), 30);
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_eq("t5_async_pos", int'(position_a), 0);
    check_eq("t5_async_air", int'(airborne_a), 0);
    check_eq("t5_async_done", int'(jump_done_a), 0);
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      check_eq("t5_traj", int'(position_a), exp1[i]);
    end

    // Saturating ascent on the high-velocity instance.
    sync_reset();
    drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
    maxp = 0;
    landed = 1'b0;
    for (int i = 0; i < 200 && !landed; i++) begin
      drive_cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (int'(position_b) > maxp) maxp = int'(position_b);
      if (!airborne_b) landed = 1'b1;
    end
    check_eq("t6_landed", int'(landed), 1);
    check_eq("t6_peak", maxp, 255);
    check_eq("t6_ground", int'(position_b), 0);

    // Random traffic against the model.
    sync_reset();
    for (int i = 0; i < 3000; i++) begin
      drive_cycle(($urandom % 3) == 0, ($urandom % 20) == 0,
                  ($urandom % 16) == 0, ($urandom % 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
